// File: rtl/seven_seg_scan.sv
// seven_seg_scan
//   Time-multiplexed driver for an N-digit common-anode 7-segment display.
//   A load strobe captures a packed hex value, decimal points and per-digit
//   blanking into a shadow copy; the shadow moves into the displayed (active)
//   copy only at a frame wrap, so a frame never shows mixed old/new data.
//   Each digit is lit for SCAN_DIV clocks, the first of which is dark (dead
//   time) to suppress ghosting.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   load       capture value_in/dp_in/blank_in (held: last cycle wins)
//   value_in   packed hex nibbles, [4i+3:4i] = digit i (digit 0 rightmost)
//   dp_in      decimal point request per digit, 1 = lit
//   blank_in   force digit dark, 1 = blank
//   seg        active-low segments, seg[0]=a .. seg[6]=g
//   dp         active-low decimal point
//   an         active-low digit enables
//   frame_done 1-cycle pulse when newly loaded data becomes active
module seven_seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shd_val;
    logic [NUM_DIGITS-1:0]   shd_dp;
    logic [NUM_DIGITS-1:0]   shd_blank;
    logic [4*NUM_DIGITS-1:0] act_val;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [NUM_DIGITS-1:0]   act_blank;
    logic                    pending;

    logic                    tc;
    logic                    wrap;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    cur_upper_zero;
    logic                    upper_zero;
    logic                    dark;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        logic [6:0] g;
        case (h)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    assign tc   = (presc == PRESC_LAST);
    assign wrap = tc && (idx == IDX_LAST);

    // Walk digits from the most significant down so that upper_zero holds
    // "every nibble at or above this digit is zero" when the current digit
    // is reached.
    always_comb begin
        cur_nib        = '0;
        cur_dp         = 1'b0;
        cur_blank      = 1'b0;
        cur_upper_zero = 1'b0;
        upper_zero     = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            upper_zero = upper_zero & (act_val[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
            if (idx == IW'(NUM_DIGITS - 1 - k)) begin
                cur_nib        = act_val[4*(NUM_DIGITS-1-k) +: 4];
                cur_dp         = act_dp[NUM_DIGITS-1-k];
                cur_blank      = act_blank[NUM_DIGITS-1-k];
                cur_upper_zero = upper_zero;
            end
        end
    end

    // A lit decimal point keeps an otherwise-leading zero visible.
    assign dark = cur_blank ||
                  ((LZ_SUPPRESS != 0) && (idx != '0) && cur_upper_zero && !cur_dp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            idx        <= '0;
            shd_val    <= '0;
            shd_dp     <= '0;
            shd_blank  <= '0;
            act_val    <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            pending    <= 1'b0;
            seg        <= '1;
            dp         <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            presc <= tc ? '0 : presc + 1'b1;
            if (tc) begin
                idx <= wrap ? '0 : idx + 1'b1;
            end

            if (load) begin
                shd_val   <= value_in;
                shd_dp    <= dp_in;
                shd_blank <= blank_in;
            end

            // A load on the wrap cycle bypasses the shadow so the very next
            // frame already shows it.
            frame_done <= 1'b0;
            if (wrap) begin
                if (load) begin
                    act_val    <= value_in;
                    act_dp     <= dp_in;
                    act_blank  <= blank_in;
                    frame_done <= 1'b1;
                end else if (pending) begin
                    act_val    <= shd_val;
                    act_dp     <= shd_dp;
                    act_blank  <= shd_blank;
                    frame_done <= 1'b1;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end

            an  <= (presc == '0) ? '1 : ~(NUM_DIGITS'(1) << idx);
            seg <= dark ? 7'h7F : glyph(cur_nib);
            dp  <= dark ? 1'b1 : ~cur_dp;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan
//   Drives two instances (leading-zero suppression on and off) with the same
//   inputs and compares both against a slot/frame reference model computed
//   from cycle counts since reset, plus fixed glyph expectations.
module tb_seven_seg_scan;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int FR = ND * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;

    logic [6:0]  seg, seg2;
    logic        dp, dp2;
    logic [3:0]  an, an2;
    logic        fd, fd2;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] OFF = 7'h7F;

    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    always #5 clk = ~clk;

    seven_seg_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .LZ_SUPPRESS(1)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in),
        .dp_in(dp_in), .blank_in(blank_in),
        .seg(seg), .dp(dp), .an(an), .frame_done(fd)
    );

    seven_seg_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .LZ_SUPPRESS(0)) dut_nolz (
        .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in),
        .dp_in(dp_in), .blank_in(blank_in),
        .seg(seg2), .dp(dp2), .an(an2), .frame_done(fd2)
    );

    // Reference model: n counts clock edges since reset release, so the
    // slot is n mod SD, the digit is (n / SD) mod ND and a frame ends on the
    // last edge of every FR-edge period.
    int          n;
    logic [15:0] m_val, s_val;
    logic [3:0]  m_dp, s_dp, m_blank, s_blank;
    logic        m_pend;
    logic [6:0]  e_seg, e_seg2;
    logic        e_dp, e_dp2, e_fd;
    logic [3:0]  e_an;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n <= 0;
            m_val <= '0; s_val <= '0;
            m_dp <= '0; s_dp <= '0;
            m_blank <= '0; s_blank <= '0;
            m_pend <= 1'b0;
            e_seg <= OFF; e_seg2 <= OFF;
            e_dp <= 1'b1; e_dp2 <= 1'b1;
            e_an <= 4'hF; e_fd <= 1'b0;
        end else begin
            automatic int  slot    = n % SD;
            automatic int  dig     = (n / SD) % ND;
            automatic bit  at_wrap = (n % FR) == FR - 1;
            automatic int  nib     = int'((m_val >> (4 * dig)) & 16'hF);
            automatic bit  pt      = m_dp[dig];
            automatic bit  forced  = m_blank[dig];
            automatic bit  lead    = (dig != 0) && ((m_val >> (4 * dig)) == 16'h0) && !pt;
            e_an   <= (slot == 0) ? 4'hF : (4'hF ^ (4'b0001 << dig));
            e_seg  <= (forced || lead) ? OFF : glyph[nib];
            e_dp   <= (forced || lead) ? 1'b1 : !pt;
            e_seg2 <= forced ? OFF : glyph[nib];
            e_dp2  <= forced ? 1'b1 : !pt;
            e_fd   <= at_wrap && (load || m_pend);
            if (at_wrap && load) begin
                m_val <= value_in; m_dp <= dp_in; m_blank <= blank_in;
            end else if (at_wrap && m_pend) begin
                m_val <= s_val; m_dp <= s_dp; m_blank <= s_blank;
            end
            if (load) begin
                s_val <= value_in; s_dp <= dp_in; s_blank <= blank_in;
            end
            m_pend <= load ? !at_wrap : (at_wrap ? 1'b0 : m_pend);
            n <= n + 1;
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value_in = v; dp_in = d; blank_in = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_fd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * FR; i++) begin
            @(negedge clk);
            if (fd === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic sync_phase(input int ph);
        for (int i = 0; i < 2 * FR; i++) begin
            @(negedge clk);
            if (n % FR == ph) return;
        end
        checks++; errors++;
        $display("FAIL sync_phase: phase %0d not reached, n=%0d", ph, n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; value_in = '0; dp_in = '0; blank_in = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({seg, dp, an, fd, seg2, dp2, an2, fd2} !==
                {OFF, 1'b1, 4'hF, 1'b0, OFF, 1'b1, 4'hF, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold: got seg=%b dp=%b an=%b fd=%b, expected 1111111 1 1111 0", seg, dp, an, fd);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (an !== 4'hF) begin
            errors++; $display("FAIL reset_first_dead: got an=%b, expected 1111", an);
        end
        @(negedge clk);
        checks++;
        if ({an, seg, dp} !== {4'b1110, G0, 1'b1}) begin
            errors++; $display("FAIL reset_first_lit: got an=%b seg=%b dp=%b, expected 1110 1000000 1", an, seg, dp);
        end
    endtask

    task automatic test_decode();
        bit ok;
        int lit = 0;
        int fds = 0;
        int d;
        logic [6:0] dec [4];
        dec[0] = 7'b0011001; dec[1] = 7'b0110000; dec[2] = 7'b0100100; dec[3] = 7'b1111001;
        do_load(16'h1234, 4'h0, 4'h0);
        wait_fd(ok);
        checks++;
        if (!ok || (n % FR) != 0) begin
            errors++; $display("FAIL decode_frame_done: got seen=%0d phase=%0d, expected seen=1 phase=0", ok, n % FR);
        end
        for (int c = 0; c < FR; c++) begin
            @(negedge clk);
            checks++;
            if ({seg, dp, an, fd, seg2, dp2, an2, fd2} !== {e_seg, e_dp, e_an, e_fd, e_seg2, e_dp2, e_an, e_fd}) begin
                errors++;
                $display("FAIL decode_model: got %b %b %b %b / %b %b, expected %b %b %b %b / %b %b",
                         seg, dp, an, fd, seg2, dp2, e_seg, e_dp, e_an, e_fd, e_seg2, e_dp2);
            end
            if (fd) fds++;
            d = -1;
            for (int k = 0; k < ND; k++) if (an == (4'hF ^ (4'b0001 << k))) d = k;
            if (d >= 0) begin
                lit++;
                checks++;
                if (seg !== dec[d]) begin
                    errors++; $display("FAIL decode_glyph digit%0d: got seg=%b, expected %b", d, seg, dec[d]);
                end
            end
        end
        checks++;
        if (lit != 12 || fds != 0) begin
            errors++; $display("FAIL decode_slots: got lit=%0d extra_fd=%0d, expected lit=12 extra_fd=0", lit, fds);
        end
    endtask

    task automatic test_lz();
        bit ok;
        int d;
        logic [15:0] vals [3];
        logic [3:0]  dps [3];
        logic [6:0]  x1, x2;
        logic        xd;
        vals[0] = 16'h0007; vals[1] = 16'h0000; vals[2] = 16'h0007;
        dps[0] = 4'b0000;   dps[1] = 4'b0000;   dps[2] = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            do_load(vals[c], dps[c], 4'h0);
            wait_fd(ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL lz_frame_done case%0d: got no pulse, expected one", c);
            end
            for (int t = 0; t < FR; t++) begin
                @(negedge clk);
                checks++;
                if ({seg, dp, an, fd, seg2, dp2, an2, fd2} !== {e_seg, e_dp, e_an, e_fd, e_seg2, e_dp2, e_an, e_fd}) begin
                    errors++;
                    $display("FAIL lz_model case%0d: got %b %b %b / %b %b, expected %b %b %b / %b %b",
                             c, seg, dp, an, seg2, dp2, e_seg, e_dp, e_an, e_seg2, e_dp2);
                end
                d = -1;
                for (int k = 0; k < ND; k++) if (an == (4'hF ^ (4'b0001 << k))) d = k;
                if (d >= 0) begin
                    if (d == 0) x1 = (c == 1) ? G0 : G7;
                    else        x1 = (c == 2 && d == 2) ? G0 : OFF;
                    x2 = (d == 0) ? x1 : G0;
                    xd = !(c == 2 && d == 2);
                    checks++;
                    if ({seg, dp, seg2, dp2} !== {x1, xd, x2, xd}) begin
                        errors++;
                        $display("FAIL lz_glyph case%0d digit%0d: got %b %b / %b %b, expected %b %b / %b %b",
                                 c, d, seg, dp, seg2, dp2, x1, xd, x2, xd);
                    end
                end
            end
        end
    endtask

    task automatic test_frame_sync();
        bit ok;
        bit seen = 1'b0;
        int after = 0;
        int t_prev = 0;
        logic [6:0] want;
        do_load(16'hAAAA, 4'h0, 4'h0);
        wait_fd(ok);
        sync_phase(5);
        do_load(16'h5555, 4'h0, 4'h0);
        for (int c = 0; c < 3 * FR && after < FR; c++) begin
            @(negedge clk);
            checks++;
            if ({seg, dp, an, fd, seg2, dp2, an2, fd2} !== {e_seg, e_dp, e_an, e_fd, e_seg2, e_dp2, e_an, e_fd}) begin
                errors++;
                $display("FAIL sync_model: got %b %b %b %b, expected %b %b %b %b", seg, dp, an, fd, e_seg, e_dp, e_an, e_fd);
            end
            if (an != 4'hF) begin
                want = seen ? 7'b0010010 : 7'b0001000;
                checks++;
                if (seg !== want) begin
                    errors++; $display("FAIL sync_no_tear: got seg=%b, expected %b (new=%0d)", seg, want, seen);
                end
            end
            if (seen) after++;
            if (fd) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL sync_frame_done: got no pulse, expected one");
        end
        for (int k = 0; k < 4; k++) begin
            sync_phase(5);
            do_load(16'($urandom), 4'h0, 4'h0);
            wait_fd(ok);
            checks++;
            if (!ok || (k > 0 && n - t_prev != FR)) begin
                errors++; $display("FAIL sync_period: got seen=%0d gap=%0d, expected seen=1 gap=%0d", ok, n - t_prev, FR);
            end
            t_prev = n;
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d;
        int dead = 0;
        logic [6:0] beef [4];
        beef[0] = 7'b0001110; beef[1] = 7'b0000110; beef[2] = 7'b0000110; beef[3] = 7'b0000011;
        sync_phase(FR - 1);
        do_load(16'hBEEF, 4'h0, 4'h0);
        checks++;
        if (fd !== 1'b1 || (n % FR) != 0) begin
            errors++; $display("FAIL wrap_load_pulse: got fd=%b phase=%0d, expected fd=1 phase=0", fd, n % FR);
        end
        for (int t = 0; t < FR; t++) begin
            @(negedge clk);
            checks++;
            if ({seg, dp, an, fd, seg2, dp2, an2, fd2} !== {e_seg, e_dp, e_an, e_fd, e_seg2, e_dp2, e_an, e_fd}) begin
                errors++;
                $display("FAIL wrap_load_model: got %b %b %b %b, expected %b %b %b %b", seg, dp, an, fd, e_seg, e_dp, e_an, e_fd);
            end
            checks++;
            if (fd !== 1'b0) begin
                errors++; $display("FAIL wrap_load_pending: got fd=%b, expected 0", fd);
            end
            d = -1;
            for (int k = 0; k < ND; k++) if (an == (4'hF ^ (4'b0001 << k))) d = k;
            if (d >= 0) begin
                checks++;
                if (seg !== beef[d]) begin
                    errors++; $display("FAIL wrap_load_glyph digit%0d: got seg=%b, expected %b", d, seg, beef[d]);
                end
            end
        end
        do_load(16'h1234, 4'b0100, 4'b0100);
        wait_fd(ok);
        for (int t = 0; t < FR; t++) begin
            @(negedge clk);
            checks++;
            if ({seg, dp, an, fd, seg2, dp2, an2, fd2} !== {e_seg, e_dp, e_an, e_fd, e_seg2, e_dp2, e_an, e_fd}) begin
                errors++;
                $display("FAIL blank_model: got %b %b %b %b, expected %b %b %b %b", seg, dp, an, fd, e_seg, e_dp, e_an, e_fd);
            end
            if (an == 4'hF) dead++;
            if (an == 4'b1011) begin
                checks++;
                if ({seg, dp, seg2, dp2} !== {OFF, 1'b1, OFF, 1'b1}) begin
                    errors++; $display("FAIL blank_digit2: got seg=%b dp=%b, expected 1111111 1", seg, dp);
                end
            end
        end
        checks++;
        if (dead != ND) begin
            errors++; $display("FAIL dead_time: got %0d dark slots, expected %0d", dead, ND);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        do_load(16'h5678, 4'b0011, 4'h0);
        wait_fd(ok);
        sync_phase(10);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({seg, dp, an, fd, seg2, dp2, an2, fd2} !== {OFF, 1'b1, 4'hF, 1'b0, OFF, 1'b1, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got seg=%b dp=%b an=%b fd=%b, expected 1111111 1 1111 0", seg, dp, an, fd);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < FR + 1; t++) begin
            @(negedge clk);
            checks++;
            if ({seg, dp, an, fd, seg2, dp2, an2, fd2} !== {e_seg, e_dp, e_an, e_fd, e_seg2, e_dp2, e_an, e_fd}) begin
                errors++;
                $display("FAIL post_reset_model: got %b %b %b %b, expected %b %b %b %b", seg, dp, an, fd, e_seg, e_dp, e_an, e_fd);
            end
            if (an != 4'hF) begin
                checks++;
                if ({seg, seg2} !== {((an == 4'b1110) ? G0 : OFF), G0}) begin
                    errors++; $display("FAIL post_reset_zero an=%b: got seg=%b seg2=%b", an, seg, seg2);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            checks++;
            if ({seg, dp, an, fd, seg2, dp2, an2, fd2} !== {e_seg, e_dp, e_an, e_fd, e_seg2, e_dp2, e_an, e_fd}) begin
                errors++;
                $display("FAIL random_model t=%0d: got %b %b %b %b / %b %b, expected %b %b %b %b / %b %b",
                         t, seg, dp, an, fd, seg2, dp2, e_seg, e_dp, e_an, e_fd, e_seg2, e_dp2);
            end
            load     = ($urandom_range(0, 5) == 0);
            value_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dp_in    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        end
        load = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode();
        test_lz();
        test_frame_sync();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
